// File: rtl/mcu_pkg.sv
// Shared encodings for the multicycle MIPS control unit:
// microprogram states, opcodes and sequencing codes.
package mcu_pkg;

    localparam int OPW     = 6;
    localparam int CNTW    = 16;
    localparam int NSTATES = 10;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        JEX     = 4'd9
    } state_t;

    typedef enum logic [1:0] {
        SEQ_FETCH = 2'b00,
        DISPATCH1 = 2'b01,
        DISPATCH2 = 2'b10,
        INCR      = 2'b11
    } addrctl_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

endpackage

// File: rtl/microsequencer_if.sv
// Bus between the microcode ROM side and the microsequencer:
// sequencing controls in, microprogram state and status out.
interface microsequencer_if #(
    parameter int OPW  = 6,
    parameter int CNTW = 16
);
    logic [1:0]      addrctl;
    logic [OPW-1:0]  opcode;
    logic            stall;
    logic [3:0]      state;
    logic            illegal_op;
    logic [CNTW-1:0] instr_count;

    modport master (
        output addrctl, opcode, stall,
        input  state, illegal_op, instr_count
    );

    modport slave (
        input  addrctl, opcode, stall,
        output state, illegal_op, instr_count
    );
endinterface

// File: rtl/dispatch_rom.sv
// Opcode dispatch tables: table 0 after DECODE,
// table 1 after MEMADR. valid=0 means no target.
module dispatch_rom
    import mcu_pkg::*;
#(
    parameter int OPW = 6
) (
    input  logic [OPW-1:0] opcode,
    input  logic           select,
    output logic [3:0]     target,
    output logic           valid
);

    logic is_r, is_lw, is_sw, is_beq, is_j;

    assign is_r   = (opcode == OPW'(OP_RTYPE));
    assign is_lw  = (opcode == OPW'(OP_LW));
    assign is_sw  = (opcode == OPW'(OP_SW));
    assign is_beq = (opcode == OPW'(OP_BEQ));
    assign is_j   = (opcode == OPW'(OP_J));

    always_comb begin
        target = FETCH;
        valid  = 1'b0;
        unique case (1'b1)
            !select && is_r: begin
                target = RTYPEEX;
                valid  = 1'b1;
            end
            !select && (is_lw || is_sw): begin
                target = MEMADR;
                valid  = 1'b1;
            end
            !select && is_beq: begin
                target = BEQEX;
                valid  = 1'b1;
            end
            !select && is_j: begin
                target = JEX;
                valid  = 1'b1;
            end
            select && is_lw: begin
                target = MEMRD;
                valid  = 1'b1;
            end
            select && is_sw: begin
                target = MEMWR;
                valid  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/microsequencer.sv
// Microprogram state register and next-state sequencing,
// with sticky illegal-opcode flag and retired-instruction count.
module microsequencer
    import mcu_pkg::*;
#(
    parameter int OPW     = mcu_pkg::OPW,
    parameter int CNTW    = mcu_pkg::CNTW,
    parameter int NSTATES = mcu_pkg::NSTATES
) (
    input logic             clk,
    input logic             rst_n,
    microsequencer_if.slave bus
);

    localparam logic [4:0] NS5 = 5'(NSTATES);

    logic [3:0]      state_q, state_d;
    logic            ill_q, ill_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [3:0]      tgt;
    logic            vld;
    logic [4:0]      inc;

    dispatch_rom #(.OPW(OPW)) u_dispatch (
        .opcode (bus.opcode),
        .select (bus.addrctl[1]),
        .target (tgt),
        .valid  (vld)
    );

    always_comb begin
        state_d = state_q;
        ill_d   = ill_q;
        cnt_d   = cnt_q;
        inc     = {1'b0, state_q} + 5'd1;
        if (!bus.stall) begin
            // a corrupted state recovers silently
            if ({1'b0, state_q} >= NS5) begin
                state_d = FETCH;
            end else begin
                unique case (1'b1)
                    bus.addrctl == SEQ_FETCH: state_d = FETCH;
                    bus.addrctl == DISPATCH1,
                    bus.addrctl == DISPATCH2: begin
                        state_d = vld ? tgt : 4'(FETCH);
                        ill_d   = ill_q | ~vld;
                    end
                    bus.addrctl == INCR:
                        state_d = (inc >= NS5) ? 4'(FETCH) : inc[3:0];
                    default: state_d = FETCH;
                endcase
                if (state_q != FETCH && state_d == FETCH)
                    cnt_d = cnt_q + CNTW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            ill_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ill_q   <= ill_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.state       = state_q;
    assign bus.illegal_op  = ill_q;
    assign bus.instr_count = cnt_q;

endmodule

// File: tb/tb_microsequencer.sv
// Scenario bench for microsequencer: expected state/count/flag
// queued at drive time, popped after each clock edge.
module tb_microsequencer;
    import mcu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    microsequencer_if #(.OPW(6), .CNTW(16)) bus ();
    microsequencer_if #(.OPW(6), .CNTW(4))  bus4 ();

    microsequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    microsequencer #(.CNTW(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    typedef struct packed {
        logic [3:0]  s;
        logic [15:0] c;
        logic        i;
    } exp_t;

    exp_t sbq[$];
    logic [3:0] sb4[$];
    int checks = 0;
    int failures = 0;
    logic [3:0]  ex_s = 4'd0;
    logic [15:0] ex_c = 16'd0;
    logic        ex_i = 1'b0;

    task automatic cyc(input logic [1:0] ac, input logic [5:0] op,
                       input logic st, input logic [3:0] es,
                       input logic ei);
        bus.addrctl = ac;
        bus.opcode  = op;
        bus.stall   = st;
        if (!st) begin
            if (ex_s != 4'd0 && es == 4'd0) ex_c = ex_c + 16'd1;
            ex_s = es;
            ex_i = ex_i | ei;
        end
        sbq.push_back('{s: ex_s, c: ex_c, i: ex_i});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        exp_t e;
        bus.addrctl = 2'b00;
        bus.opcode  = OP_RTYPE;
        bus.stall   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.state !== 4'd0 || bus.instr_count !== 16'd0 ||
            bus.illegal_op !== 1'b0) begin
            failures++;
            $display("FAIL reset_init: state=%0d cnt=%0d ill=%b required 0 0 0",
                     bus.state, bus.instr_count, bus.illegal_op);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cyc(2'b00, OP_RTYPE, 1'b0, 4'd0, 1'b0);
        cyc(2'b11, OP_RTYPE, 1'b0, 4'd1, 1'b0);
        cyc(2'b01, OP_RTYPE, 1'b0, 4'd6, 1'b0);
        for (int k = 0; k < 3; k++) begin
            e = sbq.pop_front();
            checks++;
            if (k < 2) continue;
            if (bus.state !== e.s || bus.instr_count !== e.c ||
                bus.illegal_op !== e.i) begin
                failures++;
                $display("FAIL reset_walk: state=%0d cnt=%0d ill=%b required %0d %0d %b",
                         bus.state, bus.instr_count, bus.illegal_op, e.s, e.c, e.i);
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.state !== 4'd0 || bus.instr_count !== 16'd0 ||
            bus.illegal_op !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: state=%0d cnt=%0d ill=%b required 0 0 0",
                     bus.state, bus.instr_count, bus.illegal_op);
        end
        ex_s = 4'd0;
        ex_c = 16'd0;
        ex_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc(2'b11, OP_RTYPE, 1'b0, 4'd1, 1'b0);
        e = sbq.pop_front();
        checks++;
        if (bus.state !== e.s || bus.instr_count !== e.c) begin
            failures++;
            $display("FAIL reset_release: state=%0d cnt=%0d required %0d %0d",
                     bus.state, bus.instr_count, e.s, e.c);
        end
        cyc(2'b00, OP_RTYPE, 1'b0, 4'd0, 1'b0);
        e = sbq.pop_front();
        checks++;
        if (bus.state !== e.s || bus.instr_count !== e.c) begin
            failures++;
            $display("FAIL reset_release2: state=%0d cnt=%0d required %0d %0d",
                     bus.state, bus.instr_count, e.s, e.c);
        end
    endtask

    task automatic test_rtype;
        logic [1:0] ac[4] = '{2'b11, 2'b01, 2'b11, 2'b00};
        logic [3:0] ns[4] = '{4'd1, 4'd6, 4'd7, 4'd0};
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            cyc(ac[k], OP_RTYPE, 1'b0, ns[k], 1'b0);
            e = sbq.pop_front();
            checks++;
            if (bus.state !== e.s || bus.instr_count !== e.c ||
                bus.illegal_op !== e.i) begin
                failures++;
                $display("FAIL rtype_%0d: state=%0d cnt=%0d ill=%b required %0d %0d %b",
                         k, bus.state, bus.instr_count, bus.illegal_op, e.s, e.c, e.i);
            end
        end
    endtask

    task automatic test_lw_sw;
        logic [1:0] ac[9] = '{2'b11, 2'b01, 2'b10, 2'b11, 2'b00,
                              2'b11, 2'b01, 2'b10, 2'b00};
        logic [3:0] ns[9] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0,
                              4'd1, 4'd2, 4'd5, 4'd0};
        exp_t e;
        for (int k = 0; k < 9; k++) begin
            cyc(ac[k], (k < 5) ? OP_LW : OP_SW, 1'b0, ns[k], 1'b0);
            e = sbq.pop_front();
            checks++;
            if (bus.state !== e.s || bus.instr_count !== e.c ||
                bus.illegal_op !== e.i) begin
                failures++;
                $display("FAIL lw_sw_%0d: state=%0d cnt=%0d ill=%b required %0d %0d %b",
                         k, bus.state, bus.instr_count, bus.illegal_op, e.s, e.c, e.i);
            end
        end
    endtask

    task automatic test_stall;
        logic [1:0] ac[8] = '{2'b11, 2'b01, 2'b10, 2'b10, 2'b10,
                              2'b10, 2'b11, 2'b00};
        logic [5:0] op[8] = '{OP_LW, OP_LW, 6'b111111, OP_BEQ, OP_SW,
                              OP_LW, OP_LW, OP_LW};
        logic       st[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
                              1'b0, 1'b0, 1'b0};
        logic [3:0] ns[8] = '{4'd1, 4'd2, 4'd0, 4'd0, 4'd0,
                              4'd3, 4'd4, 4'd0};
        exp_t e;
        for (int k = 0; k < 8; k++) begin
            cyc(ac[k], op[k], st[k], ns[k], 1'b0);
            e = sbq.pop_front();
            checks++;
            if (bus.state !== e.s || bus.instr_count !== e.c ||
                bus.illegal_op !== e.i) begin
                failures++;
                $display("FAIL stall_%0d: state=%0d cnt=%0d ill=%b required %0d %0d %b",
                         k, bus.state, bus.instr_count, bus.illegal_op, e.s, e.c, e.i);
            end
        end
    endtask

    task automatic test_illegal;
        logic [1:0] ac[7] = '{2'b11, 2'b01, 2'b11, 2'b01, 2'b00,
                              2'b11, 2'b10};
        logic [5:0] op[7] = '{6'b111111, 6'b111111, OP_BEQ, OP_BEQ,
                              OP_BEQ, OP_RTYPE, OP_RTYPE};
        logic [3:0] ns[7] = '{4'd1, 4'd0, 4'd1, 4'd8, 4'd0,
                              4'd1, 4'd0};
        logic       il[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                              1'b0, 1'b1};
        exp_t e;
        for (int k = 0; k < 7; k++) begin
            cyc(ac[k], op[k], 1'b0, ns[k], il[k]);
            e = sbq.pop_front();
            checks++;
            if (bus.state !== e.s || bus.instr_count !== e.c ||
                bus.illegal_op !== e.i) begin
                failures++;
                $display("FAIL illegal_%0d: state=%0d cnt=%0d ill=%b required %0d %0d %b",
                         k, bus.state, bus.instr_count, bus.illegal_op, e.s, e.c, e.i);
            end
        end
    endtask

    task automatic test_incr_jex;
        logic [1:0] ac[3] = '{2'b11, 2'b01, 2'b11};
        logic [3:0] ns[3] = '{4'd1, 4'd9, 4'd0};
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            cyc(ac[k], OP_J, 1'b0, ns[k], 1'b0);
            e = sbq.pop_front();
            checks++;
            if (bus.state !== e.s || bus.instr_count !== e.c ||
                bus.illegal_op !== e.i) begin
                failures++;
                $display("FAIL incr_jex_%0d: state=%0d cnt=%0d ill=%b required %0d %0d %b",
                         k, bus.state, bus.instr_count, bus.illegal_op, e.s, e.c, e.i);
            end
        end
    endtask

    task automatic test_count_wrap;
        logic [3:0] want;
        int n4 = 0;
        bus.addrctl = 2'b00;
        bus.stall   = 1'b0;
        bus4.opcode = OP_J;
        bus4.stall  = 1'b0;
        for (int n = 1; n <= 17; n++) begin
            bus4.addrctl = 2'b11;
            @(posedge clk);
            #1;
            bus4.addrctl = 2'b01;
            @(posedge clk);
            #1;
            bus4.addrctl = 2'b11;
            n4 = n % 16;
            sb4.push_back(4'(n4));
            @(posedge clk);
            #1;
            want = sb4.pop_front();
            checks++;
            if (bus4.instr_count !== want || bus4.state !== 4'd0) begin
                failures++;
                $display("FAIL wrap_%0d: cnt=%0d state=%0d required cnt=%0d state=0",
                         n, bus4.instr_count, bus4.state, want);
            end
        end
        bus4.addrctl = 2'b00;
    endtask

    initial begin
        bus4.addrctl = 2'b00;
        bus4.opcode  = OP_RTYPE;
        bus4.stall   = 1'b0;
        test_reset();
        test_rtype();
        test_lw_sw();
        test_stall();
        test_illegal();
        test_incr_jex();
        test_count_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
